// File: rtl/product_serializer.sv
// product_serializer: captures a parallel word on ld and shifts it out LSB-first over a valid/ready serial handshake
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   ld, din          load strobe and parallel word, accepted only while idle
//   busy             word in flight (from the cycle after load to the last accepted beat)
//   ser_valid        current beat is valid
//   ser_ready        consumer accepts the current beat
//   ser_bit          current serial bit
//   ser_last         final beat of the word
//   done             one-cycle pulse after the final beat is accepted
// Build option: PRODUCT_SERIALIZER_PARITY_EN appends an even-parity beat after the data beats.
module product_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic             done
);
`ifdef PRODUCT_SERIALIZER_PARITY_EN
    localparam int BEATS = WIDTH + 1;
`else
    localparam int BEATS = WIDTH;
`endif
    localparam int CW = $clog2(BEATS + 1);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0] cnt;
`ifdef PRODUCT_SERIALIZER_PARITY_EN
    logic par;
    // the beat after the last data bit carries the parity latched at load
    assign ser_bit = (state == SHIFT) && (cnt == CW'(WIDTH) ? par : shreg[0]);
`else
    assign ser_bit = (state == SHIFT) && shreg[0];
`endif
    assign ser_valid = state == SHIFT;
    assign busy = ser_valid;
    assign ser_last = ser_valid && cnt == LAST;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt <= '0;
            done <= 1'b0;
`ifdef PRODUCT_SERIALIZER_PARITY_EN
            par <= 1'b0;
`endif
        end else if (state == IDLE) begin
            done <= 1'b0;
            if (ld) begin
                state <= SHIFT;
                shreg <= din;
                cnt <= '0;
`ifdef PRODUCT_SERIALIZER_PARITY_EN
                par <= ^din;
`endif
            end
        end else if (ser_ready) begin
            if (cnt == LAST) begin
                state <= IDLE;
                done <= 1'b1;
            end else begin
                shreg <= shreg >> 1;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_product_serializer.sv
// tb_product_serializer: randomized self-checking bench for product_serializer against a word-level bit-order model
module tb_product_serializer;
    localparam int W = 8;
`ifdef PRODUCT_SERIALIZER_PARITY_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ld = 1'b0;
    logic ser_ready = 1'b0;
    logic [W-1:0] din = '0;
    logic busy, ser_valid, ser_bit, ser_last, done;
    int compared = 0;
    int mismatched = 0;
    logic [W:0] obs_word, last_mask;
    int obs_n, busy_cyc, valid_cyc, stall_bad, done_early, stalls;
    logic first_valid, done_after, idle_after, timed_out;

    product_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .ld(ld), .din(din), .busy(busy),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_bit(ser_bit),
        .ser_last(ser_last), .done(done)
    );

    always #5 clk = ~clk;

    // expected beat stream of one word: data bits LSB first, then the even parity of the word if enabled
    function automatic logic [W:0] model_bits(input logic [W-1:0] d);
        logic [W:0] r;
        int p;
        r = '0;
        p = 0;
        for (int i = 0; i < W; i++) begin
            r[i] = d[i];
            p += int'(d[i]);
        end
        if (N > W) r[W] = p[0];
        return r;
    endfunction

    function automatic logic [W:0] model_last();
        logic [W:0] r;
        r = '0;
        r[N-1] = 1'b1;
        return r;
    endfunction

    // mode 0: ready always high, 1: random ready, 2: three-cycle stall after beat 2
    task automatic drive_word(input logic [W-1:0] d, input int mode, input bit ld_busy, input int rst_at);
        logic pv, pr, pb, pl, acc, acc_last;
        obs_word = '0; last_mask = '0; obs_n = 0; busy_cyc = 0; valid_cyc = 0;
        stall_bad = 0; done_early = 0; stalls = 0; timed_out = 1'b0;
        done_after = 1'b0; idle_after = 1'b0;
        pv = 1'b0; pr = 1'b1; pb = 1'b0; pl = 1'b0;
        ld = 1'b1; din = d; ser_ready = 1'b1;
        @(negedge clk);
        ld = 1'b0; din = W'($urandom);
        first_valid = ser_valid;
        for (int c = 0; c < 500; c++) begin
            if (busy) busy_cyc++;
            if (ser_valid) valid_cyc++;
            if (done) done_early++;
            if (pv && !pr && (ser_bit !== pb || ser_last !== pl || ser_valid !== 1'b1)) stall_bad++;
            if (rst_at >= 0 && obs_n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            ser_ready = mode == 1 ? ($urandom_range(2) != 0) : 1'b1;
            if (mode == 2 && obs_n == 2 && stalls < 3) begin
                ser_ready = 1'b0;
                stalls++;
            end
            if (ld_busy && obs_n == 3) begin
                ld = 1'b1;
                din = '0;
            end
            pv = ser_valid; pr = ser_ready; pb = ser_bit; pl = ser_last;
            acc = ser_valid && ser_ready;
            acc_last = acc && ser_last;
            if (acc && obs_n <= W) begin
                obs_word[obs_n] = ser_bit;
                last_mask[obs_n] = ser_last;
            end
            if (acc) obs_n++;
            @(negedge clk);
            ld = 1'b0;
            if (acc_last || obs_n > W) begin
                done_after = done;
                idle_after = !busy && !ser_valid;
                return;
            end
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ld = 1'b0; ser_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            compared++;
            if ({busy, ser_valid, ser_bit, ser_last, done} !== 5'b0) begin
                mismatched++;
                $display("FAIL reset_idle cycle %0d: got busy/valid/bit/last/done=%b expected 00000", i, {busy, ser_valid, ser_bit, ser_last, done});
            end
        end
    endtask

    task automatic test_word(input string name, input logic [W-1:0] d, input int mode, input bit ld_busy);
        logic [W:0] exp_bits;
        exp_bits = ld_busy ? model_bits(W'('1)) : model_bits(d);
        drive_word(d, mode, ld_busy, -1);
        compared++;
        if (timed_out || obs_n != N || obs_word !== exp_bits) begin
            mismatched++;
            $display("FAIL %s bits din=%h: got %b (%0d beats, timeout=%b) expected %b (%0d beats)", name, d, obs_word, obs_n, timed_out, exp_bits, N);
        end
        compared++;
        if (last_mask !== model_last()) begin
            mismatched++;
            $display("FAIL %s last: got mask %b expected %b", name, last_mask, model_last());
        end
        compared++;
        if (first_valid !== 1'b1 || done_after !== 1'b1 || idle_after !== 1'b1 || done_early != 0) begin
            mismatched++;
            $display("FAIL %s handshake: got first_valid=%b done_after=%b idle_after=%b early_done=%0d expected 1 1 1 0", name, first_valid, done_after, idle_after, done_early);
        end
        compared++;
        if (busy_cyc != valid_cyc || (mode != 1 && busy_cyc != N + stalls) || stall_bad != 0) begin
            mismatched++;
            $display("FAIL %s busy: got busy=%0d valid=%0d stall_errors=%0d expected busy=valid=%0d stall_errors=0", name, busy_cyc, valid_cyc, stall_bad, N + stalls);
        end
    endtask

    task automatic test_done_drop();
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || ser_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL done_pulse_width: got done=%b valid=%b expected 0 0", done, ser_valid);
        end
    endtask

    task automatic test_basic();
        test_word("basic_a5", 8'hA5, 0, 1'b0);
        test_done_drop();
    endtask

    task automatic test_stall();
        test_word("stall_3c", 8'h3C, 2, 1'b0);
        test_done_drop();
    endtask

    task automatic test_load_while_busy();
        test_word("load_busy_ff", 8'hFF, 0, 1'b1);
        test_done_drop();
    endtask

    task automatic test_reset_mid_word();
        drive_word(8'hA5, 0, 1'b0, 4);
        for (int i = 0; i < 2; i++) begin
            compared++;
            if ({busy, ser_valid, ser_bit, ser_last, done} !== 5'b0) begin
                mismatched++;
                $display("FAIL reset_mid cycle %0d: got busy/valid/bit/last/done=%b expected 00000", i, {busy, ser_valid, ser_bit, ser_last, done});
            end
            @(negedge clk);
        end
        test_word("after_reset_01", 8'h01, 0, 1'b0);
        test_done_drop();
    endtask

    task automatic test_back_to_back();
        test_word("b2b_first", W'($urandom), 0, 1'b0);
        test_word("b2b_second", W'($urandom), 0, 1'b0);
        test_done_drop();
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            test_word("random", W'($urandom), 1, 1'b0);
            if ($urandom_range(1) != 0) test_done_drop();
        end
        test_done_drop();
    endtask

    task automatic test_parity();
`ifdef PRODUCT_SERIALIZER_PARITY_EN
        test_word("parity_a5", 8'hA5, 0, 1'b0);
        compared++;
        if (obs_word[W] !== 1'b0) begin
            mismatched++;
            $display("FAIL parity_a5 bit: got %b expected 0", obs_word[W]);
        end
        test_word("parity_07", 8'h07, 2, 1'b0);
        compared++;
        if (obs_word[W] !== 1'b1) begin
            mismatched++;
            $display("FAIL parity_07 bit: got %b expected 1", obs_word[W]);
        end
        test_done_drop();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_load_while_busy();
        test_reset_mid_word();
        test_back_to_back();
        test_random();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
